// File: rtl/fireberd_pacer_pkg.sv
// Shared types and defaults for the Fireberd nibble pacer.
package fireberd_pacer_pkg;

   localparam int unsigned NIBBLE_BITS     = 4;
   localparam int unsigned DEF_DEPTH       = 16;
   localparam int unsigned DEF_PRIME_LEVEL = 8;
   localparam int unsigned DEF_CPB_W       = 16;

   typedef logic [NIBBLE_BITS-1:0] nibble_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2
   } pacer_state_e;

   typedef struct packed {
      logic overflow;
      logic underflow;
   } pacer_flags_t;

endpackage

// File: rtl/fireberd_pacer_nibble_fifo.sv
// Synchronous nibble FIFO with clock enable and flush; level is a registered counter.
module fireberd_pacer_nibble_fifo
   import fireberd_pacer_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   ce_i,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  nibble_t                data_i,
   output nibble_t                head_c_o,
   output logic                   full_c_o,
   output logic                   empty_c_o,
   output logic [$clog2(DEPTH):0] level_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   nibble_t         mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic            push_ok, pop_ok;

   assign full_c_o  = (level_q == LW'(DEPTH));
   assign empty_c_o = (level_q == '0);
   assign head_c_o  = mem_q[rd_ptr_q];
   assign level_o   = level_q;

   // Pop needs data; push needs room unless a same-cycle pop frees a slot.
   always_comb begin
      pop_ok   = pop_i && !empty_c_o;
      push_ok  = push_i && (!full_c_o || pop_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
         level_d = level_q + LW'(push_ok) - LW'(pop_ok);
      end
   end

   // Pointer and level registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else if (ce_i) begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array; contents are only meaningful between the pointers.
   always_ff @(posedge clk_i) begin
      if (ce_i && push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/fireberd_pacer.sv
// Elastic buffer and rate scheduler feeding evenly spaced nibbles to the Fireberd drive stage.
module fireberd_pacer
   import fireberd_pacer_pkg::*;
#(
   parameter int unsigned DEPTH       = DEF_DEPTH,
   parameter int unsigned PRIME_LEVEL = DEF_PRIME_LEVEL,
   parameter int unsigned CPB_W       = DEF_CPB_W
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   ce,
   input  logic                   enable,
   input  logic                   validIn,
   input  logic [NIBBLE_BITS-1:0] dataIn,
   input  logic [CPB_W-1:0]       clocksPerBit,
   input  logic                   clearFlags,
   output logic                   validOut,
   output logic [NIBBLE_BITS-1:0] dataOut,
   output logic [$clog2(DEPTH):0] fifoLevel,
   output logic                   running,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;
   localparam int unsigned PACE_W = CPB_W + 3;

   pacer_state_e      state_q, state_d;
   logic [PACE_W-1:0] pace_q, pace_d;
   logic              valid_q, valid_d;
   nibble_t           data_q, data_d;
   logic              running_q, running_d;
   pacer_flags_t      flags_q, flags_d;

   logic              fifo_flush, fifo_push, fifo_pop, push_req;
   logic              fifo_full, fifo_empty;
   nibble_t           fifo_head;
   logic [LVL_W-1:0]  fifo_level;
   logic              ovf_set, unf_set;
   logic [PACE_W-1:0] pace_reload_c;

   // One nibble every 4*(clocksPerBit+1) cycles; sampled only at reload.
   assign pace_reload_c = ((PACE_W'(clocksPerBit) + PACE_W'(1)) << 2) - PACE_W'(1);

   fireberd_pacer_nibble_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i     (clk),
      .rst_ni    (reset_n),
      .ce_i      (ce),
      .flush_i   (fifo_flush),
      .push_i    (fifo_push),
      .pop_i     (fifo_pop),
      .data_i    (dataIn),
      .head_c_o  (fifo_head),
      .full_c_o  (fifo_full),
      .empty_c_o (fifo_empty),
      .level_o   (fifo_level)
   );

   // Next-state, pacing tick decision, FIFO control and sticky flag update.
   always_comb begin
      state_d    = state_q;
      pace_d     = pace_q;
      valid_d    = 1'b0;
      data_d     = data_q;
      fifo_flush = 1'b0;
      fifo_pop   = 1'b0;
      push_req   = 1'b0;
      unf_set    = 1'b0;

      if (!enable) begin
         state_d    = ST_IDLE;
         pace_d     = '0;
         fifo_flush = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               fifo_flush = 1'b1;
               state_d    = ST_PRIME;
            end
            ST_PRIME: begin
               push_req = validIn;
               if (fifo_level >= LVL_W'(PRIME_LEVEL)) begin
                  state_d = ST_RUN;
                  pace_d  = '0;
               end
            end
            ST_RUN: begin
               push_req = validIn;
               if (pace_q == '0) begin
                  if (!fifo_empty) begin
                     fifo_pop = 1'b1;
                     valid_d  = 1'b1;
                     data_d   = fifo_head;
                     pace_d   = pace_reload_c;
                  end else begin
                     // Empty at a tick: no bypass of a same-cycle write.
                     unf_set = 1'b1;
                     state_d = ST_PRIME;
                  end
               end else begin
                  pace_d = pace_q - PACE_W'(1);
               end
            end
            default: begin
               state_d    = ST_IDLE;
               fifo_flush = 1'b1;
            end
         endcase
      end

      fifo_push = push_req && (!fifo_full || fifo_pop);
      ovf_set   = push_req && fifo_full && !fifo_pop;
      running_d = (state_d == ST_RUN);

      flags_d.overflow  = ovf_set | (flags_q.overflow  & ~clearFlags);
      flags_d.underflow = unf_set | (flags_q.underflow & ~clearFlags);
   end

   // State, pace counter and output registers; everything frozen while ce is low.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         pace_q    <= '0;
         valid_q   <= 1'b0;
         data_q    <= '0;
         running_q <= 1'b0;
         flags_q   <= '0;
      end else if (ce) begin
         state_q   <= state_d;
         pace_q    <= pace_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         running_q <= running_d;
         flags_q   <= flags_d;
      end
   end

   assign validOut  = valid_q;
   assign dataOut   = data_q;
   assign fifoLevel = fifo_level;
   assign running   = running_q;
   assign overflow  = flags_q.overflow;
   assign underflow = flags_q.underflow;

endmodule

// File: tb/tb_fireberd_pacer.sv
// Self-checking bench for fireberd_pacer against a queue-based behavioural model.
module tb_fireberd_pacer;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned PRIME = 8;
   localparam int unsigned CPB_W = 16;

   logic             clk = 1'b0;
   logic             reset_n = 1'b1;
   logic             ce = 1'b1;
   logic             enable = 1'b0;
   logic             validIn = 1'b0;
   logic [3:0]       dataIn = 4'h0;
   logic [CPB_W-1:0] clocksPerBit = 16'd3;
   logic             clearFlags = 1'b0;
   logic             validOut;
   logic [3:0]       dataOut;
   logic [4:0]       fifoLevel;
   logic             running, overflow, underflow;

   int errors = 0;
   int checks = 0;

   fireberd_pacer #(.DEPTH(DEPTH), .PRIME_LEVEL(PRIME), .CPB_W(CPB_W)) dut (
      .clk(clk), .reset_n(reset_n), .ce(ce), .enable(enable),
      .validIn(validIn), .dataIn(dataIn), .clocksPerBit(clocksPerBit),
      .clearFlags(clearFlags), .validOut(validOut), .dataOut(dataOut),
      .fifoLevel(fifoLevel), .running(running), .overflow(overflow),
      .underflow(underflow)
   );

   always #5 clk = ~clk;

   // Behavioural model: a queue of nibbles, a mode and a countdown to the next tick.
   logic [3:0]  m_q [$];
   int          m_mode;     // 0 idle, 1 priming, 2 running
   int unsigned m_wait;
   logic        e_valid, e_ovf, e_unf, m_ovf_ev, m_unf_ev;
   logic [3:0]  e_data;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_q.delete();
         m_mode = 0; m_wait = 0;
         e_valid = 1'b0; e_data = 4'h0; e_ovf = 1'b0; e_unf = 1'b0;
      end else if (ce) begin
         m_ovf_ev = 1'b0; m_unf_ev = 1'b0; e_valid = 1'b0;
         if (!enable) begin
            m_q.delete(); m_mode = 0; m_wait = 0;
         end else if (m_mode == 0) begin
            m_mode = 1;
         end else begin
            if (m_mode == 1) begin
               if (m_q.size() >= PRIME) begin m_mode = 2; m_wait = 0; end
            end else if (m_wait != 0) begin
               m_wait = m_wait - 1;
            end else if (m_q.size() != 0) begin
               e_data  = m_q.pop_front();
               e_valid = 1'b1;
               m_wait  = 4 * (int'(clocksPerBit) + 1) - 1;
            end else begin
               m_unf_ev = 1'b1; m_mode = 1;
            end
            if (validIn) begin
               if (m_q.size() < DEPTH) m_q.push_back(dataIn);
               else m_ovf_ev = 1'b1;
            end
         end
         e_ovf = m_ovf_ev | (e_ovf & ~clearFlags);
         e_unf = m_unf_ev | (e_unf & ~clearFlags);
      end
   end

   function automatic logic [12:0] dut_vec();
      return {validOut, dataOut, fifoLevel, running, overflow, underflow};
   endfunction

   function automatic logic [12:0] model_vec();
      return {e_valid, e_data, 5'(m_q.size()), (m_mode == 2), e_ovf, e_unf};
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      ce = 1'b1; enable = 1'b0; validIn = 1'b0; clearFlags = 1'b0;
      reset_n = 1'b0;
      tick(); tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (dut_vec() !== 13'h0) begin
            errors++; $display("FAIL reset c=%0d got=%h exp=%h", c, dut_vec(), 13'h0);
         end
         tick();
      end
   endtask

   task automatic test_in_order();
      int pc[$];
      logic [3:0] pd[$];
      do_reset();
      clocksPerBit = 16'd3; enable = 1'b1;
      for (int c = 0; c < 150; c++) begin
         validIn = (c >= 1 && c <= 8);
         dataIn  = 4'(c - 1);
         tick();
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL in_order c=%0d got=%h exp=%h", c, dut_vec(), model_vec());
         end
         if (validOut === 1'b1) begin pc.push_back(c); pd.push_back(dataOut); end
         if (c == 9) begin
            checks++;
            if (running !== 1'b1) begin errors++; $display("FAIL in_order_running got=%b exp=1", running); end
         end
      end
      validIn = 1'b0;
      checks++;
      if (pc.size() != 8) begin
         errors++; $display("FAIL in_order_count got=%0d exp=8", pc.size());
      end else begin
         checks++;
         if (pc[0] - 8 != 2) begin errors++; $display("FAIL in_order_latency got=%0d exp=2", pc[0] - 8); end
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (pd[i] !== 4'(i)) begin errors++; $display("FAIL in_order_data i=%0d got=%h exp=%h", i, pd[i], 4'(i)); end
            if (i > 0) begin
               checks++;
               if (pc[i] - pc[i-1] != 16) begin errors++; $display("FAIL in_order_spacing i=%0d got=%0d exp=16", i, pc[i] - pc[i-1]); end
            end
         end
      end
   endtask

   task automatic test_bursty();
      int pc[$];
      do_reset();
      clocksPerBit = 16'd3; enable = 1'b1;
      for (int c = 0; c < 12 * 64; c++) begin
         validIn = (c >= 1) && (((c - 1) % 64) < 4);
         dataIn  = 4'($urandom);
         tick();
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL bursty c=%0d got=%h exp=%h", c, dut_vec(), model_vec());
         end
         if (validOut === 1'b1) pc.push_back(c);
      end
      validIn = 1'b0;
      checks++;
      if (underflow !== 1'b0) begin errors++; $display("FAIL bursty_underflow got=%b exp=0", underflow); end
      checks++;
      if (pc.size() < 30) begin errors++; $display("FAIL bursty_count got=%0d exp>=30", pc.size()); end
      for (int i = 1; i < pc.size(); i++) begin
         checks++;
         if (pc[i] - pc[i-1] != 16) begin errors++; $display("FAIL bursty_spacing i=%0d got=%0d exp=16", i, pc[i] - pc[i-1]); end
      end
   endtask

   // The 9th push lands as PRIME hands over to RUN and the first tick pops one,
   // so 18 back-to-back pushes are needed to drop exactly one nibble.
   task automatic test_overflow();
      logic [3:0] pd[$];
      do_reset();
      clocksPerBit = 16'd3; enable = 1'b1;
      for (int c = 0; c < 300; c++) begin
         validIn    = (c >= 1 && c <= 18);
         dataIn     = (c == 18) ? 4'hF : 4'((c - 1) % 15);
         clearFlags = (c == 19);
         tick();
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL overflow c=%0d got=%h exp=%h", c, dut_vec(), model_vec());
         end
         if (validOut === 1'b1) pd.push_back(dataOut);
         if (c == 18) begin
            checks++;
            if (fifoLevel !== 5'd16 || overflow !== 1'b1) begin
               errors++; $display("FAIL overflow_full got lvl=%0d ovf=%b exp lvl=16 ovf=1", fifoLevel, overflow);
            end
         end
         if (c == 19) begin
            checks++;
            if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear got=%b exp=0", overflow); end
         end
      end
      validIn = 1'b0; clearFlags = 1'b0;
      checks++;
      if (pd.size() != 17) begin
         errors++; $display("FAIL overflow_count got=%0d exp=17", pd.size());
      end else begin
         for (int i = 0; i < 17; i++) begin
            checks++;
            if (pd[i] !== 4'(i % 15)) begin errors++; $display("FAIL overflow_data i=%0d got=%h exp=%h", i, pd[i], 4'(i % 15)); end
         end
      end
   endtask

   task automatic test_starve();
      int pc[$];
      do_reset();
      clocksPerBit = 16'd1; enable = 1'b1;
      for (int c = 0; c < 100; c++) begin
         validIn = (c >= 1 && c <= 8) || (c >= 80 && c <= 87);
         dataIn  = 4'($urandom);
         tick();
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL starve c=%0d got=%h exp=%h", c, dut_vec(), model_vec());
         end
         if (validOut === 1'b1 && c < 80) pc.push_back(c);
         if (c == 76) begin
            checks++;
            if (underflow !== 1'b1 || running !== 1'b0) begin
               errors++; $display("FAIL starve_underflow got unf=%b run=%b exp unf=1 run=0", underflow, running);
            end
         end
         if (c == 89) begin
            checks++;
            if (running !== 1'b1) begin errors++; $display("FAIL starve_resume got=%b exp=1", running); end
         end
      end
      validIn = 1'b0;
      checks++;
      if (pc.size() != 8) begin errors++; $display("FAIL starve_count got=%0d exp=8", pc.size()); end
      for (int i = 1; i < pc.size(); i++) begin
         checks++;
         if (pc[i] - pc[i-1] != 8) begin errors++; $display("FAIL starve_spacing i=%0d got=%0d exp=8", i, pc[i] - pc[i-1]); end
      end
   endtask

   task automatic test_disable();
      logic [3:0] saved;
      bit hit;
      do_reset();
      clocksPerBit = 16'd3; enable = 1'b1;
      for (int c = 0; c < 9; c++) begin
         validIn = (c >= 1); dataIn = 4'($urandom);
         tick();
      end
      validIn = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 100 && !hit; c++) begin
         tick();
         if (fifoLevel === 5'd5) hit = 1'b1;
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL disable_wait got lvl=%0d exp=5", fifoLevel); end
      tick();
      saved = dataOut;
      enable = 1'b0; validIn = 1'b1;
      tick();
      checks++;
      if (fifoLevel !== 5'd0 || validOut !== 1'b0 || dataOut !== saved) begin
         errors++; $display("FAIL disable_flush got lvl=%0d v=%b d=%h exp lvl=0 v=0 d=%h", fifoLevel, validOut, dataOut, saved);
      end
      for (int c = 0; c < 12; c++) begin
         enable = (c >= 3);
         validIn = 1'b1; dataIn = 4'($urandom);
         tick();
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL disable c=%0d got=%h exp=%h", c, dut_vec(), model_vec());
         end
      end
      validIn = 1'b0;
   endtask

   task automatic test_reset_freeze();
      bit hit;
      logic [4:0] lvl;
      do_reset();
      clocksPerBit = 16'd3; enable = 1'b1;
      hit = 1'b0;
      for (int c = 0; c < 40 && !hit; c++) begin
         validIn = (c >= 1 && c <= 8); dataIn = 4'($urandom);
         tick();
         if (validOut === 1'b1) hit = 1'b1;
      end
      validIn = 1'b0;
      checks++;
      if (!hit) begin errors++; $display("FAIL freeze_wait_pulse got=0 exp=1"); end
      #1 reset_n = 1'b0;
      #1;
      checks++;
      if (dut_vec() !== 13'h0) begin errors++; $display("FAIL async_reset got=%h exp=%h", dut_vec(), 13'h0); end
      #1 reset_n = 1'b1;
      for (int c = 0; c < 230; c++) begin
         validIn = (c >= 1 && c <= 10);
         dataIn  = 4'($urandom);
         ce      = !(c >= 30 && c < 130);
         if (c == 30) lvl = fifoLevel;
         tick();
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL freeze c=%0d got=%h exp=%h", c, dut_vec(), model_vec());
         end
         if (c >= 30 && c < 130) begin
            checks++;
            if (fifoLevel !== lvl) begin errors++; $display("FAIL freeze_level c=%0d got=%0d exp=%0d", c, fifoLevel, lvl); end
         end
      end
      validIn = 1'b0; ce = 1'b1;
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) clocksPerBit = 16'($urandom_range(0, 3));
         ce         = ($urandom_range(0, 9) != 0);
         enable     = ($urandom_range(0, 149) != 0);
         validIn    = ($urandom_range(0, 3) == 0);
         dataIn     = 4'($urandom);
         clearFlags = ($urandom_range(0, 19) == 0);
         tick();
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL random c=%0d got=%h exp=%h", c, dut_vec(), model_vec());
         end
      end
      validIn = 1'b0; clearFlags = 1'b0; ce = 1'b1;
   endtask

   initial begin
      #1;
      test_reset();
      test_in_order();
      test_bursty();
      test_overflow();
      test_starve();
      test_disable();
      test_reset_freeze();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1, "simulation time limit reached");
   end

endmodule
